// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with saturating, glitch-free output
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t                r_state, w_next;
  logic [WIDTH-1:0]      r_shreg;
  logic [BW-1:0]         r_scratch, w_adj;
  logic [BW+WIDTH-1:0]   w_sh;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf_pend, w_accept, w_last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ? r_scratch[4*d +: 4] + 4'd3 : r_scratch[4*d +: 4];
  end
  assign w_sh     = {w_adj, r_shreg} << 1;
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == CONV) && (r_cnt == CW'(1));
  assign busy     = (r_state == CONV);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state: accept in IDLE, leave CONV after the last bit
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? CONV : w_last ? IDLE : r_state;
  end
  // datapath: load, shift-add-3 iteration, and result write only on the final iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_shreg    <= bin_in;
        r_scratch  <= '0;
        r_cnt      <= CW'(WIDTH);
        r_ovf_pend <= 32'(bin_in) > MAXV;
      end else if (r_state == CONV) begin
        r_scratch <= w_sh[BW+WIDTH-1:WIDTH];
        r_shreg   <= w_sh[WIDTH-1:0];
        r_cnt     <= r_cnt - CW'(1);
        if (w_last) begin
          bcd_out <= r_ovf_pend ? {DIGITS{4'h9}} : w_sh[BW+WIDTH-1:WIDTH];
          ovf     <= r_ovf_pend;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule
